fetch_pc_sequencer: RTL and testbench
=====================================

Name: fetch_pc_sequencer

Overview:
Next-PC controller for the superscalar instruction-fetch stage. It issues fetch-group requests to the instruction cache and pairs each response with a slot mask for the fetch queue. The next PC is selected from four sources in fixed priority: backend flush, decode redirect, predicted-taken branch, and sequential. Outstanding cache responses are dropped after any redirect.

Parameters:
PC_BITS, 32, width of all PC ports
FETCH_WIDTH, 2, instruction slots per fetch group (power of 2)
INSTR_BYTES, 4, bytes per instruction (power of 2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush_valid_i  in  1  backend flush; highest priority
flush_pc_i  in  PC_BITS  flush target
dec_redir_valid_i  in  1  decode-stage redirect
dec_redir_pc_i  in  PC_BITS  decode redirect target
pred_taken_i  in  1  predictor: group at ic_resp contains a taken branch (sampled with ic_resp_valid_i)
pred_slot_i  in  log2(FETCH_WIDTH)  slot index of the taken branch
pred_target_i  in  PC_BITS  predicted target
ic_req_valid_o  out  1  cache request valid
ic_req_pc_o  out  PC_BITS  cache request PC
ic_req_ready_i  in  1  cache accepts request
ic_resp_valid_i  in  1  cache response for the last accepted request
out_valid_o  out  1  fetch group valid toward fetch queue
out_pc_o  out  PC_BITS  PC of the group (unaligned start PC)
out_mask_o  out  FETCH_WIDTH  valid-slot mask, bit0 = lowest address
out_ready_i  in  1  fetch queue accepts group
busy_o  out  1  request or response outstanding

Behaviour:
- Derived values: GB = FETCH_WIDTH*INSTR_BYTES; base(pc) = pc with the low log2(GB) bits cleared; off(pc) = slot index of pc inside its group.
- Reset (asynchronous): state=BOOT, pc_q=RESET_PC, drop_q=0. All outputs 0, except ic_req_pc_o=RESET_PC.
- BOOT: moves to FETCH one cycle after rst deasserts.
- FETCH: ic_req_valid_o=1 and ic_req_pc_o=pc_q, both held stable until ic_req_ready_i. On the handshake cycle, go to WAIT.
- WAIT: waits for ic_resp_valid_i.
  - If drop_q=1, the response is discarded: clear drop_q and go to FETCH.
  - Otherwise register the output group: out_pc_o=pc_q and out_mask_o = bits off(pc_q)..FETCH_WIDTH-1 set.
  - If pred_taken_i and pred_slot_i>=off(pc_q), also clear the mask bits above pred_slot_i and set next_pc=pred_target_i.
  - Otherwise next_pc = base(pc_q)+GB, wrapping modulo 2^PC_BITS.
  - A pred_slot_i below off(pc_q) is ignored and treated as not taken.
  - Go to HOLD with out_valid_o=1 from the next cycle.
- HOLD: out_valid_o, out_pc_o and out_mask_o stay stable until out_ready_i. On the accept cycle: pc_q=next_pc, out_valid_o=0 the next cycle, go to FETCH. No new request is issued while in HOLD.
- Redirect in any state other than BOOT:
  - flush_valid_i wins over dec_redir_valid_i when both are asserted.
  - Next cycle: pc_q = redirect PC, out_valid_o=0 (the held group is discarded even if out_ready_i was high), state=FETCH.
  - If redirected in WAIT before the response arrives, or in FETCH on the request-handshake cycle, set drop_q=1. At most one response is outstanding.
  - A redirect takes priority over a same-cycle ic_resp_valid_i; that response is discarded.
- Request issue after redirect, when drop_q=1: the new request is issued, but the first returned response is discarded and the request is re-sent. The returned response is attributed to the old request.
- busy_o=1 in WAIT or when drop_q=1.
- Reset asserted mid-operation returns everything to reset values immediately; no handshakes complete.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds three 32-bit outputs, each saturating at 0xFFFFFFFF and cleared by rst:
- perf_groups_o: accepted groups
- perf_redirects_o: flushes plus decode redirects
- perf_dropped_o: discarded responses

When not defined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset release, ic_req_ready_i/ic_resp_valid_i/out_ready_i always 1, no predictions -> requests at 0, 8, 16; out_mask_o=2'b11 each.
- Response for pc 8 with pred_taken_i=1, pred_slot_i=0, target 40 -> out_mask_o=2'b01, next request pc 40.
- dec redirect to 44 -> request 44, out_pc_o=44, out_mask_o=2'b10, next request 48.
- flush to 100 while in WAIT, stale ic_resp_valid_i 2 cycles later -> stale response dropped with no out_valid_o, then request 100 and mask 2'b10.
- flush_pc_i=200 and dec_redir_pc_i=300 in the same cycle -> next request pc 200.
- out_ready_i low for 3 cycles after a group -> out_valid_o/out_pc_o/out_mask_o stable, ic_req_valid_o=0; accept on cycle 4 -> request base+8 one cycle later.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// Next-PC sequencer for the fetch stage: issues I-cache requests and pairs each response with a slot mask.
// Optional macro IF_PERF_CNT_EN adds saturating perf counters for groups, redirects and dropped responses.
module fetch_pc_sequencer #(
   parameter int                 PC_BITS     = 32,
   parameter int                 FETCH_WIDTH = 2,
   parameter int                 INSTR_BYTES = 4,
   parameter logic [PC_BITS-1:0] RESET_PC    = '0,
   localparam int                SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_valid_i,
   input  logic [PC_BITS-1:0]     flush_pc_i,
   input  logic                   dec_redir_valid_i,
   input  logic [PC_BITS-1:0]     dec_redir_pc_i,
   input  logic                   pred_taken_i,
   input  logic [SLOT_W-1:0]      pred_slot_i,
   input  logic [PC_BITS-1:0]     pred_target_i,
   output logic                   ic_req_valid_o,
   output logic [PC_BITS-1:0]     ic_req_pc_o,
   input  logic                   ic_req_ready_i,
   input  logic                   ic_resp_valid_i,
   output logic                   out_valid_o,
   output logic [PC_BITS-1:0]     out_pc_o,
   output logic [FETCH_WIDTH-1:0] out_mask_o,
   input  logic                   out_ready_i,
   output logic                   busy_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]            perf_groups_o,
   output logic [31:0]            perf_redirects_o,
   output logic [31:0]            perf_dropped_o
`endif
);

   localparam int                 OFF_LSB   = $clog2(INSTR_BYTES);
   localparam int                 GB        = FETCH_WIDTH * INSTR_BYTES;
   localparam logic [PC_BITS-1:0] GB_PC     = PC_BITS'(GB);
   localparam logic [PC_BITS-1:0] OFF_MASK  = PC_BITS'(GB - 1);
   localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(FETCH_WIDTH - 1);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [PC_BITS-1:0]     pc_q, pc_d;
   logic [PC_BITS-1:0]     next_pc_q, next_pc_d;
   logic                   drop_q, drop_d;
   logic                   out_valid_q, out_valid_d;
   logic [PC_BITS-1:0]     out_pc_q, out_pc_d;
   logic [FETCH_WIDTH-1:0] out_mask_q, out_mask_d;

   logic                   redir;
   logic [PC_BITS-1:0]     redir_pc;
   logic                   req_hs;
   logic [SLOT_W-1:0]      off;
   logic                   taken_ok;
   logic [FETCH_WIDTH-1:0] ones;
   logic [FETCH_WIDTH-1:0] head_mask;
   logic [FETCH_WIDTH-1:0] tail_mask;

   assign redir     = flush_valid_i | dec_redir_valid_i;
   assign redir_pc  = flush_valid_i ? flush_pc_i : dec_redir_pc_i;
   assign req_hs    = (state_q == ST_FETCH) && ic_req_ready_i;
   assign off       = pc_q[OFF_LSB +: SLOT_W];
   assign taken_ok  = pred_taken_i && (pred_slot_i >= off);
   assign ones      = '1;
   assign head_mask = ones << off;
   assign tail_mask = ones >> (LAST_SLOT - pred_slot_i);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      next_pc_d   = next_pc_q;
      drop_d      = drop_q;
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_mask_d  = out_mask_q;
      if (state_q == ST_BOOT) begin
         state_d = ST_FETCH;
      end else if (redir) begin
         pc_d        = redir_pc;
         out_valid_d = 1'b0;
         state_d     = ST_FETCH;
         // A same-cycle response in WAIT is consumed here, so only a still-pending one needs dropping.
         if (req_hs)
            drop_d = 1'b1;
         else if (state_q == ST_WAIT)
            drop_d = !ic_resp_valid_i;
      end else begin
         case (state_q)
            ST_FETCH: if (ic_req_ready_i) state_d = ST_WAIT;
            ST_WAIT: begin
               if (ic_resp_valid_i) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = ST_FETCH;
                  end else begin
                     out_valid_d = 1'b1;
                     out_pc_d    = pc_q;
                     out_mask_d  = taken_ok ? (head_mask & tail_mask) : head_mask;
                     next_pc_d   = taken_ok ? pred_target_i : (pc_q & ~OFF_MASK) + GB_PC;
                     state_d     = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready_i) begin
                  pc_d        = next_pc_q;
                  out_valid_d = 1'b0;
                  state_d     = ST_FETCH;
               end
            end
            default: state_d = ST_BOOT;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         next_pc_q   <= '0;
         drop_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_mask_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         next_pc_q   <= next_pc_d;
         drop_q      <= drop_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_mask_q  <= out_mask_d;
      end
   end

   assign ic_req_valid_o = (state_q == ST_FETCH);
   assign ic_req_pc_o    = pc_q;
   assign out_valid_o    = out_valid_q;
   assign out_pc_o       = out_pc_q;
   assign out_mask_o     = out_mask_q;
   assign busy_o         = (state_q == ST_WAIT) || drop_q;

`ifdef IF_PERF_CNT_EN
   logic ev_group, ev_redir, ev_drop;

   assign ev_group = (state_q == ST_HOLD) && out_ready_i && !redir;
   assign ev_redir = (state_q != ST_BOOT) && redir;
   assign ev_drop  = (state_q == ST_WAIT) && ic_resp_valid_i && (drop_q || redir);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_groups_o    <= '0;
         perf_redirects_o <= '0;
         perf_dropped_o   <= '0;
      end else begin
         if (ev_group && (perf_groups_o != '1))    perf_groups_o    <= perf_groups_o + 32'd1;
         if (ev_redir && (perf_redirects_o != '1)) perf_redirects_o <= perf_redirects_o + 32'd1;
         if (ev_drop && (perf_dropped_o != '1))    perf_dropped_o   <= perf_dropped_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the fetch sequencing rules.
module tb_fetch_pc_sequencer;

   localparam int PC_BITS     = 32;
   localparam int FETCH_WIDTH = 2;
   localparam int INSTR_BYTES = 4;
   localparam int GB          = FETCH_WIDTH * INSTR_BYTES;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   flush_valid_i;
   logic [PC_BITS-1:0]     flush_pc_i;
   logic                   dec_redir_valid_i;
   logic [PC_BITS-1:0]     dec_redir_pc_i;
   logic                   pred_taken_i;
   logic [0:0]             pred_slot_i;
   logic [PC_BITS-1:0]     pred_target_i;
   logic                   ic_req_valid_o;
   logic [PC_BITS-1:0]     ic_req_pc_o;
   logic                   ic_req_ready_i;
   logic                   ic_resp_valid_i;
   logic                   out_valid_o;
   logic [PC_BITS-1:0]     out_pc_o;
   logic [FETCH_WIDTH-1:0] out_mask_o;
   logic                   out_ready_i;
   logic                   busy_o;

   fetch_pc_sequencer #(
      .PC_BITS(PC_BITS), .FETCH_WIDTH(FETCH_WIDTH), .INSTR_BYTES(INSTR_BYTES), .RESET_PC('0)
   ) dut (
      .clk(clk), .rst(rst),
      .flush_valid_i(flush_valid_i), .flush_pc_i(flush_pc_i),
      .dec_redir_valid_i(dec_redir_valid_i), .dec_redir_pc_i(dec_redir_pc_i),
      .pred_taken_i(pred_taken_i), .pred_slot_i(pred_slot_i), .pred_target_i(pred_target_i),
      .ic_req_valid_o(ic_req_valid_o), .ic_req_pc_o(ic_req_pc_o), .ic_req_ready_i(ic_req_ready_i),
      .ic_resp_valid_i(ic_resp_valid_i),
      .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_mask_o(out_mask_o), .out_ready_i(out_ready_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: where fetch is, whether a request/group is in flight, stale responses owed.
   bit                 m_boot, m_wait, m_hold, m_stale;
   logic [PC_BITS-1:0] m_pc, m_gpc, m_after;
   logic [1:0]         m_gmask;

   function automatic logic [1:0] spec_mask(input logic [31:0] pc, input bit taken, input int slot);
      int off = int'((pc / INSTR_BYTES) % FETCH_WIDTH);
      logic [1:0] m = '0;
      for (int s = 0; s < FETCH_WIDTH; s++)
         if (s >= off && (!(taken && slot >= off) || s <= slot)) m[s] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] spec_next(input logic [31:0] pc, input bit taken, input int slot,
                                             input logic [31:0] tgt);
      int off = int'((pc / INSTR_BYTES) % FETCH_WIDTH);
      if (taken && slot >= off) return tgt;
      return (pc - (pc % GB)) + GB;
   endfunction

   task automatic model_reset();
      m_boot = 1; m_wait = 0; m_hold = 0; m_stale = 0; m_pc = '0;
   endtask

   task automatic model_step();
      bit fetching;
      if (rst) begin model_reset(); return; end
      fetching = !m_boot && !m_wait && !m_hold;
      if (m_boot) m_boot = 0;
      else if (flush_valid_i || dec_redir_valid_i) begin
         if (fetching && ic_req_ready_i) m_stale = 1;
         else if (m_wait) m_stale = !ic_resp_valid_i;
         m_pc   = flush_valid_i ? flush_pc_i : dec_redir_pc_i;
         m_wait = 0;
         m_hold = 0;
      end else if (fetching) begin
         if (ic_req_ready_i) m_wait = 1;
      end else if (m_wait) begin
         if (ic_resp_valid_i) begin
            m_wait = 0;
            if (m_stale) m_stale = 0;
            else begin
               m_gpc   = m_pc;
               m_gmask = spec_mask(m_pc, pred_taken_i, int'(pred_slot_i));
               m_after = spec_next(m_pc, pred_taken_i, int'(pred_slot_i), pred_target_i);
               m_hold  = 1;
            end
         end
      end else if (m_hold && out_ready_i) begin
         m_pc   = m_after;
         m_hold = 0;
      end
   endtask

   task automatic compare();
      check("req_valid", 64'(ic_req_valid_o), 64'(!m_boot && !m_wait && !m_hold));
      check("req_pc", 64'(ic_req_pc_o), 64'(m_pc));
      check("out_valid", 64'(out_valid_o), 64'(m_hold));
      check("busy", 64'(busy_o), 64'(m_wait || m_stale));
      if (m_hold) begin
         check("out_pc", 64'(out_pc_o), 64'(m_gpc));
         check("out_mask", 64'(out_mask_o), 64'(m_gmask));
      end
   endtask

   logic [31:0] req_log[$];
   logic [31:0] grp_pc[$];
   logic [1:0]  grp_mask[$];
   int          hold_cycles;

   // Inputs are set at a negedge by the caller; one tick spans the next posedge and negedge.
   task automatic tick();
      #1;
      if (!rst && ic_req_valid_o && ic_req_ready_i) req_log.push_back(ic_req_pc_o);
      if (!rst && out_valid_o && out_ready_i) begin
         grp_pc.push_back(out_pc_o);
         grp_mask.push_back(out_mask_o);
      end
      if (!rst && out_valid_o && !ic_req_valid_o) hold_cycles++;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic idle_inputs();
      flush_valid_i = 0; flush_pc_i = '0; dec_redir_valid_i = 0; dec_redir_pc_i = '0;
      pred_taken_i = 0; pred_slot_i = '0; pred_target_i = '0;
      ic_req_ready_i = 0; ic_resp_valid_i = 0; out_ready_i = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      idle_inputs();
      model_reset();
      #1;
      check("reset_req_valid", 64'(ic_req_valid_o), 64'(0));
      check("reset_req_pc", 64'(ic_req_pc_o), 64'(0));
      check("reset_out_valid", 64'(out_valid_o), 64'(0));
      check("reset_busy", 64'(busy_o), 64'(0));
      tick();
      rst = 0;
      req_log.delete(); grp_pc.delete(); grp_mask.delete(); hold_cycles = 0;
   endtask

   task automatic all_ready();
      ic_req_ready_i = 1; ic_resp_valid_i = 1; out_ready_i = 1;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      model_reset();
      @(negedge clk);

      // Sequential fetch with everything ready.
      do_reset();
      all_ready();
      repeat (9) tick();
      check("seq_nreq", 64'(req_log.size()), 64'(3));
      if (req_log.size() >= 3) begin
         check("seq_req0", 64'(req_log[0]), 64'(0));
         check("seq_req1", 64'(req_log[1]), 64'(8));
         check("seq_req2", 64'(req_log[2]), 64'(16));
      end
      if (grp_mask.size() >= 2) begin
         check("seq_mask0", 64'(grp_mask[0]), 64'(2'b11));
         check("seq_mask1", 64'(grp_mask[1]), 64'(2'b11));
      end

      // Taken branch in slot 0 of the group at 8, target 40.
      do_reset();
      all_ready();
      for (int c = 0; c < 12; c++) begin
         pred_taken_i = m_wait && (m_pc == 8);
         pred_slot_i = '0;
         pred_target_i = 32'd40;
         tick();
      end
      check("pred_nreq", 64'(req_log.size()), 64'(4));
      if (req_log.size() >= 4) begin
         check("pred_req2", 64'(req_log[2]), 64'(40));
         check("pred_req3", 64'(req_log[3]), 64'(48));
      end
      if (grp_mask.size() >= 2) begin
         check("pred_grp_pc", 64'(grp_pc[1]), 64'(8));
         check("pred_grp_mask", 64'(grp_mask[1]), 64'(2'b01));
      end

      // Decode redirect to 44 while the first request is not yet accepted.
      do_reset();
      tick();
      dec_redir_valid_i = 1; dec_redir_pc_i = 32'd44;
      tick();
      dec_redir_valid_i = 0;
      all_ready();
      repeat (6) tick();
      if (req_log.size() >= 2) begin
         check("dec_req0", 64'(req_log[0]), 64'(44));
         check("dec_req1", 64'(req_log[1]), 64'(48));
      end else check("dec_nreq", 64'(req_log.size()), 64'(2));
      if (grp_pc.size() >= 1) begin
         check("dec_grp_pc", 64'(grp_pc[0]), 64'(44));
         check("dec_grp_mask", 64'(grp_mask[0]), 64'(2'b10));
      end else check("dec_ngrp", 64'(grp_pc.size()), 64'(1));

      // Flush to 100 while waiting; stale response two cycles later is dropped and 100 re-sent.
      do_reset();
      ic_req_ready_i = 1; out_ready_i = 1;
      tick(); tick();
      flush_valid_i = 1; flush_pc_i = 32'd100;
      tick();
      flush_valid_i = 0;
      tick();
      ic_resp_valid_i = 1;
      repeat (5) tick();
      check("flush_nreq", 64'(req_log.size()), 64'(4));
      if (req_log.size() >= 4) begin
         check("flush_req1", 64'(req_log[1]), 64'(100));
         check("flush_req2", 64'(req_log[2]), 64'(100));
         check("flush_req3", 64'(req_log[3]), 64'(104));
      end
      check("flush_ngrp", 64'(grp_pc.size()), 64'(1));
      if (grp_pc.size() >= 1) begin
         check("flush_grp_pc", 64'(grp_pc[0]), 64'(100));
         check("flush_grp_mask", 64'(grp_mask[0]), 64'(2'b10));
      end

      // Flush and decode redirect together: flush wins.
      do_reset();
      tick();
      flush_valid_i = 1; flush_pc_i = 32'd200;
      dec_redir_valid_i = 1; dec_redir_pc_i = 32'd300;
      tick();
      flush_valid_i = 0; dec_redir_valid_i = 0;
      all_ready();
      tick();
      if (req_log.size() >= 1) check("prio_req0", 64'(req_log[0]), 64'(200));
      else check("prio_nreq", 64'(req_log.size()), 64'(1));

      // Back-pressure: group held for three cycles, accepted on the fourth.
      do_reset();
      ic_req_ready_i = 1; ic_resp_valid_i = 1; out_ready_i = 0;
      repeat (6) tick();
      out_ready_i = 1;
      repeat (2) tick();
      check("hold_cycles", 64'(hold_cycles), 64'(4));
      check("hold_nreq", 64'(req_log.size()), 64'(2));
      if (req_log.size() >= 2) check("hold_req1", 64'(req_log[1]), 64'(8));
      if (grp_pc.size() >= 1) check("hold_grp_mask", 64'(grp_mask[0]), 64'(2'b11));

      // Randomized traffic, including occasional asynchronous resets mid-operation.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            flush_valid_i     = ($urandom_range(0, 19) == 0);
            flush_pc_i        = $urandom;
            dec_redir_valid_i = ($urandom_range(0, 14) == 0);
            dec_redir_pc_i    = $urandom;
            pred_taken_i      = $urandom_range(0, 1) == 1;
            pred_slot_i       = 1'($urandom_range(0, 1));
            pred_target_i     = $urandom;
            ic_req_ready_i    = ($urandom_range(0, 9) < 7);
            ic_resp_valid_i   = ($urandom_range(0, 1) == 1);
            out_ready_i       = ($urandom_range(0, 9) < 6);
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
